// File: rtl/ram_arb_pkg.sv
// Shared encodings for the three-requester round-robin RAM arbiter.
// Holds the FSM states, the "no owner" grant code and the ring step helper.
package ram_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    // Step around the 0->1->2->0 ring; an out-of-range index restarts at 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick3.sv
// Combinational round-robin picker: first asserted request after 'last'.
// Returns GRANT_NONE when nobody is requesting.
module rr_pick3
    import ram_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] win
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Search order starts one past the previous owner and wraps.
    always_comb begin
        first_s  = rr_next(last);
        second_s = rr_next(first_s);
        third_s  = rr_next(second_s);
        if (req[first_s]) begin
            win = first_s;
        end else if (req[second_s]) begin
            win = second_s;
        end else if (req[third_s]) begin
            win = third_s;
        end else begin
            win = GRANT_NONE;
        end
    end

endmodule

// File: rtl/ram_arb_rr.sv
// Three-port round-robin arbiter in front of a single shared RAM port,
// with a per-transfer wait timeout that errors the owner and parks in RECOVER.
module ram_arb_rr
    import ram_arb_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             wb_clk,
    input  logic             wb_rst,

    input  logic             p0_cyc,
    input  logic             p0_we,
    input  logic [3:0]       p0_sel,
    input  logic [WIDTH-1:0] p0_adr,
    input  logic [31:0]      p0_dat,
    output logic             p0_ack,
    output logic             p0_err,
    output logic [31:0]      p0_rdt,

    input  logic             p1_cyc,
    input  logic             p1_we,
    input  logic [3:0]       p1_sel,
    input  logic [WIDTH-1:0] p1_adr,
    input  logic [31:0]      p1_dat,
    output logic             p1_ack,
    output logic             p1_err,
    output logic [31:0]      p1_rdt,

    input  logic             p2_cyc,
    input  logic             p2_we,
    input  logic [3:0]       p2_sel,
    input  logic [WIDTH-1:0] p2_adr,
    input  logic [31:0]      p2_dat,
    output logic             p2_ack,
    output logic             p2_err,
    output logic [31:0]      p2_rdt,

    output logic             x_cyc,
    output logic             x_we,
    output logic [3:0]       x_sel,
    output logic [WIDTH-1:0] x_adr,
    output logic [31:0]      x_dat,
    input  logic             x_ack,
    input  logic [31:0]      x_rdt,

    output logic [1:0]       grant
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       wait_q, wait_d;

    logic [2:0]       cyc_s;
    logic [1:0]       win_s;
    logic             own_cyc_s;
    logic             own_we_s;
    logic [3:0]       own_sel_s;
    logic [WIDTH-1:0] own_adr_s;
    logic [31:0]      own_dat_s;
    logic [2:0]       own_oh_s;
    logic             busy_s;
    logic             timeout_s;
    logic             resp_live_s;
    logic [2:0]       ack_vec_s;
    logic [2:0]       err_vec_s;
    logic [31:0]      rdt_s;

    assign cyc_s = {p2_cyc, p1_cyc, p0_cyc};

    rr_pick3 u_pick (
        .req  (cyc_s),
        .last (last_q),
        .win  (win_s)
    );

    // Select the current owner's request fields.
    always_comb begin
        case (owner_q)
            2'd0: begin
                own_cyc_s = p0_cyc;
                own_we_s  = p0_we;
                own_sel_s = p0_sel;
                own_adr_s = p0_adr;
                own_dat_s = p0_dat;
            end
            2'd1: begin
                own_cyc_s = p1_cyc;
                own_we_s  = p1_we;
                own_sel_s = p1_sel;
                own_adr_s = p1_adr;
                own_dat_s = p1_dat;
            end
            2'd2: begin
                own_cyc_s = p2_cyc;
                own_we_s  = p2_we;
                own_sel_s = p2_sel;
                own_adr_s = p2_adr;
                own_dat_s = p2_dat;
            end
            default: begin
                own_cyc_s = 1'b0;
                own_we_s  = 1'b0;
                own_sel_s = 4'd0;
                own_adr_s = {WIDTH{1'b0}};
                own_dat_s = 32'd0;
            end
        endcase
    end

    assign busy_s    = (state_q == ST_BUSY);
    // An ack in the same cycle as the limit wins over the timeout.
    assign timeout_s = busy_s && !x_ack && (wait_q == WAIT_LAST);

    // State register with synchronous reset.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: grant, hold, release, timeout and recovery.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (|cyc_s) begin
                    state_d = ST_BUSY;
                    owner_d = win_s;
                    wait_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (timeout_s) begin
                    state_d = ST_RECOVER;
                end else if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (x_ack) begin
                    wait_d = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_RECOVER: begin
                if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: shared-port drive, per-port responses and grant code.
    always_comb begin
        if (busy_s) begin
            x_cyc = 1'b1;
            x_we  = own_we_s;
            x_sel = own_sel_s;
            x_adr = own_adr_s;
            x_dat = own_dat_s;
        end else begin
            x_cyc = 1'b0;
            x_we  = 1'b0;
            x_sel = 4'd0;
            x_adr = {WIDTH{1'b0}};
            x_dat = 32'd0;
        end

        // Responses are suppressed while reset is asserted so an aborted
        // transfer never reports completion or error.
        resp_live_s = busy_s && !wb_rst;
        own_oh_s    = 3'b001 << owner_q;
        ack_vec_s   = {3{resp_live_s && x_ack}} & own_oh_s;
        err_vec_s   = {3{timeout_s && !wb_rst}} & own_oh_s;
        if ((|ack_vec_s) && !own_we_s) begin
            rdt_s = x_rdt;
        end else begin
            rdt_s = 32'd0;
        end

        p0_ack = ack_vec_s[0];
        p1_ack = ack_vec_s[1];
        p2_ack = ack_vec_s[2];
        p0_err = err_vec_s[0];
        p1_err = err_vec_s[1];
        p2_err = err_vec_s[2];
        p0_rdt = ack_vec_s[0] ? rdt_s : 32'd0;
        p1_rdt = ack_vec_s[1] ? rdt_s : 32'd0;
        p2_rdt = ack_vec_s[2] ? rdt_s : 32'd0;

        case (state_q)
            ST_BUSY:    grant = owner_q;
            ST_RECOVER: grant = owner_q;
            default:    grant = GRANT_NONE;
        endcase
    end

endmodule

// File: tb/tb_ram_arb_rr.sv
// Directed bench for ram_arb_rr: drives requesters and a scripted RAM,
// scoreboards completed transfers and checks grant order and timeouts.
module tb_ram_arb_rr;

    localparam int WIDTH = 10;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic [2:0]        p_cyc, p_we, p_ack, p_err;
    logic [3:0]        p_sel [3];
    logic [WIDTH-1:0]  p_adr [3];
    logic [31:0]       p_dat [3];
    logic [31:0]       p_rdt [3];
    logic              x_cyc, x_we, x_ack;
    logic [3:0]        x_sel;
    logic [WIDTH-1:0]  x_adr;
    logic [31:0]       x_dat, x_rdt;
    logic [1:0]        grant;

    typedef struct {
        int          port;
        logic [31:0] rdt;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    always #5 wb_clk = ~wb_clk;

    ram_arb_rr #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
        .wb_clk (wb_clk), .wb_rst (wb_rst),
        .p0_cyc (p_cyc[0]), .p0_we (p_we[0]), .p0_sel (p_sel[0]), .p0_adr (p_adr[0]),
        .p0_dat (p_dat[0]), .p0_ack (p_ack[0]), .p0_err (p_err[0]), .p0_rdt (p_rdt[0]),
        .p1_cyc (p_cyc[1]), .p1_we (p_we[1]), .p1_sel (p_sel[1]), .p1_adr (p_adr[1]),
        .p1_dat (p_dat[1]), .p1_ack (p_ack[1]), .p1_err (p_err[1]), .p1_rdt (p_rdt[1]),
        .p2_cyc (p_cyc[2]), .p2_we (p_we[2]), .p2_sel (p_sel[2]), .p2_adr (p_adr[2]),
        .p2_dat (p_dat[2]), .p2_ack (p_ack[2]), .p2_err (p_err[2]), .p2_rdt (p_rdt[2]),
        .x_cyc  (x_cyc), .x_we (x_we), .x_sel (x_sel), .x_adr (x_adr), .x_dat (x_dat),
        .x_ack  (x_ack), .x_rdt (x_rdt),
        .grant  (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard and quiet-port monitor, sampled mid low phase.
    always @(negedge wb_clk) begin
        #3;
        if (mon_en) begin
            for (int n = 0; n < 3; n++) begin
                if (p_ack[n] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_ack", 32'(n), 32'd99);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_port", 32'(n), 32'(e.port));
                        chk("sb_rdt", p_rdt[n], e.rdt);
                    end
                end
                if (grant != 2'(n)) begin
                    chk("nonowner_quiet", 32'({p_ack[n], p_err[n]}) | p_rdt[n], 32'd0);
                end
            end
            if (grant == 2'd3) begin
                chk("idle_x_quiet", 32'({x_cyc, x_we, x_sel}) | 32'(x_adr) | x_dat, 32'd0);
            end
        end
    end

    task automatic wait_grant(input int exp_g, input int exp_idle, input string tag);
        int idle;
        bit got;
        idle = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge wb_clk);
            #1;
            if (grant != 2'd3) got = 1'b1;
            else               idle++;
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
            chk({tag, "_idle"}, 32'(idle), 32'(exp_idle));
        end
    endtask

    // Ack one cycle, then release the port (optionally raising others).
    task automatic ack_now(input int port, input logic [31:0] rdt,
                           input logic [31:0] exp_rdt, input logic [2:0] raise);
        @(negedge wb_clk);
        x_ack = 1'b1;
        x_rdt = rdt;
        sb_q.push_back('{port, exp_rdt});
        #1;
        chk("ack_hi", 32'(p_ack[port]), 32'd1);
        chk("ack_no_err", 32'(p_err[port]), 32'd0);
        @(negedge wb_clk);
        x_ack = 1'b0;
        x_rdt = 32'd0;
        p_cyc[port] = 1'b0;
        p_cyc = p_cyc | raise;
        #1;
        chk("ack_one_cycle", 32'(p_ack[port]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        #1;
        chk("reset_grant", 32'(grant), 32'd3);
    endtask

    initial begin
        wb_rst = 1'b1;
        p_cyc = 3'b000;
        p_we  = 3'b000;
        x_ack = 1'b0;
        x_rdt = 32'd0;
        for (int n = 0; n < 3; n++) begin
            p_sel[n] = 4'hF;
            p_adr[n] = 10'd0;
            p_dat[n] = 32'd0;
        end
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd3);
        chk("rst_x_cyc", 32'(x_cyc), 32'd0);
        chk("rst_acks", 32'({p_ack, p_err}), 32'd0);
        mon_en = 1'b1;

        // p0 read of address 5, RAM answers two cycles into BUSY
        @(negedge wb_clk);
        p_cyc[0] = 1'b1; p_we[0] = 1'b0; p_adr[0] = 10'd5;
        wait_grant(0, 0, "rd");
        chk("rd_x_cyc", 32'(x_cyc), 32'd1);
        chk("rd_x_adr", 32'(x_adr), 32'd5);
        chk("rd_x_we", 32'(x_we), 32'd0);
        @(negedge wb_clk);
        #1;
        chk("rd_no_early_ack", 32'(p_ack[0]), 32'd0);
        ack_now(0, 32'h1234_5678, 32'h1234_5678, 3'b000);
        chk("rd_p12_quiet", 32'({p_ack[2:1], p_err[2:1]}) | p_rdt[1] | p_rdt[2], 32'd0);

        // All three requesting: expect 0,1,2,0 with one idle cycle between owners
        do_reset();
        @(negedge wb_clk);
        p_cyc = 3'b111;
        p_we  = 3'b000;
        wait_grant(0, 0, "rr0");
        ack_now(0, 32'h0000_0A00, 32'h0000_0A00, 3'b000);
        wait_grant(1, 1, "rr1");
        ack_now(1, 32'h0000_0A01, 32'h0000_0A01, 3'b001);
        wait_grant(2, 1, "rr2");
        ack_now(2, 32'h0000_0A02, 32'h0000_0A02, 3'b000);
        wait_grant(0, 1, "rr3");
        ack_now(0, 32'h0000_0A03, 32'h0000_0A03, 3'b000);

        // p1 write, top address, read data must stay 0
        @(negedge wb_clk);
        p_cyc[1] = 1'b1; p_we[1] = 1'b1; p_sel[1] = 4'b0011;
        p_adr[1] = 10'h3FF; p_dat[1] = 32'hA5A5_A5A5;
        wait_grant(1, 0, "wr");
        chk("wr_x_dat", x_dat, 32'hA5A5_A5A5);
        chk("wr_x_sel", 32'(x_sel), 32'h3);
        chk("wr_x_we", 32'(x_we), 32'd1);
        chk("wr_x_adr", 32'(x_adr), 32'h3FF);
        ack_now(1, 32'hDEAD_BEEF, 32'd0, 3'b000);
        p_we[1] = 1'b0;

        // No ack ever: err on 15th BUSY cycle, then RECOVER until cyc drops
        @(negedge wb_clk);
        p_cyc[0] = 1'b1;
        wait_grant(0, 0, "to");
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) begin
                @(negedge wb_clk);
                #1;
            end
            chk($sformatf("to_err_c%0d", c), 32'(p_err[0]), (c == 15) ? 32'd1 : 32'd0);
        end
        @(negedge wb_clk);
        #1;
        chk("to_rec_x_cyc", 32'(x_cyc), 32'd0);
        chk("to_rec_grant", 32'(grant), 32'd0);
        chk("to_rec_err", 32'(p_err[0]), 32'd0);
        @(negedge wb_clk);
        x_ack = 1'b1;
        #1;
        chk("to_rec_ack_ignored", 32'(p_ack[0]), 32'd0);
        @(negedge wb_clk);
        x_ack = 1'b0;
        p_cyc[0] = 1'b0;
        #1;
        chk("to_rec_hold", 32'(grant), 32'd0);
        @(negedge wb_clk);
        #1;
        chk("to_idle", 32'(grant), 32'd3);

        // Ack exactly at the limit wins and restarts the count
        @(negedge wb_clk);
        p_cyc[0] = 1'b1;
        wait_grant(0, 0, "lim");
        for (int c = 2; c <= 14; c++) begin
            @(negedge wb_clk);
            #1;
            chk("lim_pre_err", 32'(p_err[0]), 32'd0);
        end
        @(negedge wb_clk);
        x_ack = 1'b1;
        x_rdt = 32'hCAFE_F00D;
        sb_q.push_back('{0, 32'hCAFE_F00D});
        #1;
        chk("lim_ack", 32'(p_ack[0]), 32'd1);
        chk("lim_no_err", 32'(p_err[0]), 32'd0);
        for (int c = 16; c <= 30; c++) begin
            @(negedge wb_clk);
            x_ack = 1'b0;
            x_rdt = 32'd0;
            #1;
            chk($sformatf("lim_post_c%0d", c), 32'(p_err[0]), (c == 30) ? 32'd1 : 32'd0);
        end
        @(negedge wb_clk);
        p_cyc[0] = 1'b0;
        @(negedge wb_clk);
        #1;
        chk("lim_idle", 32'(grant), 32'd3);

        // Reset mid-BUSY with a coincident ack: nothing reported, p0 next
        @(negedge wb_clk);
        p_cyc[1] = 1'b1;
        wait_grant(1, 0, "rb");
        @(negedge wb_clk);
        wb_rst = 1'b1;
        x_ack  = 1'b1;
        x_rdt  = 32'h5555_AAAA;
        #1;
        chk("rb_no_ack", 32'({p_ack, p_err}), 32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        x_ack  = 1'b0;
        x_rdt  = 32'd0;
        p_cyc  = 3'b011;
        #1;
        chk("rb_grant_none", 32'(grant), 32'd3);
        chk("rb_quiet", 32'({p_ack, p_err, x_cyc}), 32'd0);
        wait_grant(0, 0, "rb_next");
        ack_now(0, 32'h0BAD_0000, 32'h0BAD_0000, 3'b000);
        wait_grant(1, 1, "rb_then");
        ack_now(1, 32'h0BAD_0001, 32'h0BAD_0001, 3'b000);

        @(negedge wb_clk);
        #4;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
